// File: rtl/ic_test_sequencer.sv
// Functional tester for one logic-gate IC: walks every input vector, settles, samples and compares.
// Optional IC_SEQ_EARLY_ABORT_EN stops the test at the first sample that records a mismatch.
module ic_test_sequencer #(
    parameter int SETTLE_CYCLES = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] gate,
    input  logic [2:0] tester,
    input  logic       unsupported,
    input  logic [5:0] dut_out,
    output logic [7:0] dut_in,
    output logic       dut_oe,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] gate_fail,
    output logic       invalid
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_APPLY, S_SETTLE, S_SAMPLE, S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  gate_q, tester_q;
    logic        unsup_q;
    logic [8:0]  vec_cnt;
    logic [9:0]  settle_cnt;
    logic        accept, code_bad, vec_last, exp_bit;
    logic [5:0]  mismatch;

    // Mask of the input bits one gate of this topology actually uses.
    function automatic logic [7:0] in_mask(input logic [2:0] t);
        case (t)
            3'b000:  in_mask = 8'h01;
            3'b001:  in_mask = 8'h03;
            3'b010:  in_mask = 8'h07;
            3'b011:  in_mask = 8'h0f;
            default: in_mask = 8'hff;
        endcase
    endfunction

    function automatic logic [5:0] gate_mask(input logic [2:0] t);
        case (t)
            3'b000:  gate_mask = 6'b111111;
            3'b001:  gate_mask = 6'b001111;
            3'b010:  gate_mask = 6'b000111;
            3'b011:  gate_mask = 6'b000011;
            default: gate_mask = 6'b000001;
        endcase
    endfunction

    // Unused input bits are forced to the reduction's neutral value.
    function automatic logic expected_bit(input logic [2:0] g, input logic [2:0] t,
                                          input logic [7:0] v);
        logic [7:0] m;
        m = in_mask(t);
        if (t == 3'b000) begin
            expected_bit = ~v[0];
        end else begin
            case (g)
                3'b000:  expected_bit = &(v | ~m);
                3'b001:  expected_bit = |(v & m);
                3'b010:  expected_bit = ~&(v | ~m);
                3'b011:  expected_bit = ~|(v & m);
                default: expected_bit = ^(v & m);
            endcase
        end
    endfunction

    assign accept   = start && (state == S_IDLE || state == S_DONE);
    assign code_bad = unsup_q || (tester_q > 3'd4) || ((gate_q > 3'd4) && (tester_q != 3'd0));
    assign vec_last = (vec_cnt == {1'b0, in_mask(tester_q)});
    assign exp_bit  = expected_bit(gate_q, tester_q, dut_in);
    assign mismatch = ({6{exp_bit}} ^ dut_out) & gate_mask(tester_q);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_CHECK;
            S_CHECK:        state_nxt = code_bad ? S_DONE : S_APPLY;
            S_APPLY:        state_nxt = S_SETTLE;
            S_SETTLE:       if (settle_cnt == 10'd0) state_nxt = S_SAMPLE;
            S_SAMPLE: begin
`ifdef IC_SEQ_EARLY_ABORT_EN
                state_nxt = (vec_last || (|mismatch)) ? S_DONE : S_APPLY;
`else
                state_nxt = vec_last ? S_DONE : S_APPLY;
`endif
            end
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == S_CHECK) || (state == S_APPLY) ||
                 (state == S_SETTLE) || (state == S_SAMPLE);
        dut_oe = (state == S_APPLY) || (state == S_SETTLE) || (state == S_SAMPLE);
        dut_in = dut_oe ? (vec_cnt[7:0] & in_mask(tester_q)) : 8'h00;
        done   = (state == S_DONE);
        pass   = done && !invalid && !(|gate_fail);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            gate_q     <= 3'd0;
            tester_q   <= 3'd0;
            unsup_q    <= 1'b0;
            vec_cnt    <= 9'd0;
            settle_cnt <= 10'd0;
            gate_fail  <= 6'd0;
            invalid    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                gate_q    <= gate;
                tester_q  <= tester;
                unsup_q   <= unsupported;
                vec_cnt   <= 9'd0;
                gate_fail <= 6'd0;
                invalid   <= 1'b0;
            end
            case (state)
                S_CHECK:  if (code_bad) invalid <= 1'b1;
                S_APPLY:  settle_cnt <= 10'(SETTLE_CYCLES - 1);
                S_SETTLE: if (settle_cnt != 10'd0) settle_cnt <= settle_cnt - 10'd1;
                S_SAMPLE: begin
                    gate_fail <= gate_fail | mismatch;
                    if (!vec_last) vec_cnt <= vec_cnt + 9'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ic_test_sequencer.sv
// Directed bench for ic_test_sequencer with a behavioural socket IC model and a result scoreboard.
module tb_ic_test_sequencer;

    localparam int SETTLE = 4;
    localparam int VC     = SETTLE + 2;
    localparam int LIMIT  = 3000;

    logic       clk = 1'b0;
    logic       reset, start, unsupported;
    logic [2:0] gate, tester;
    logic [5:0] dut_out;
    logic [7:0] dut_in;
    logic       dut_oe, busy, done, pass, invalid;
    logic [5:0] gate_fail;

    logic [2:0] m_gate, m_tester;
    logic [5:0] m_stuck0, m_orout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         lat;
        logic       pass_e;
        logic [5:0] gf;
        logic       inv;
        int         nvec;
    } exp_t;

    exp_t sb[$];

    ic_test_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .reset(reset), .start(start), .gate(gate), .tester(tester),
        .unsupported(unsupported), .dut_out(dut_out), .dut_in(dut_in), .dut_oe(dut_oe),
        .busy(busy), .done(done), .pass(pass), .gate_fail(gate_fail), .invalid(invalid)
    );

    always #5 clk = ~clk;

    // Socket IC: correct gates unless a fault is injected; unused gate positions drive wrong values.
    function automatic logic [5:0] model_out(input logic [7:0] v, input logic [2:0] g,
                                             input logic [2:0] t, input logic [5:0] st0,
                                             input logic [5:0] orv);
        int n, ng;
        logic a, o, x, b;
        logic [5:0] r;
        case (t)
            3'd0:    begin n = 1; ng = 6; end
            3'd1:    begin n = 2; ng = 4; end
            3'd2:    begin n = 3; ng = 3; end
            3'd3:    begin n = 4; ng = 2; end
            default: begin n = 8; ng = 1; end
        endcase
        a = 1'b1; o = 1'b0; x = 1'b0;
        for (int i = 0; i < n; i++) begin
            a = a & v[i];
            o = o | v[i];
            x = x ^ v[i];
        end
        if (t == 3'd0) b = ~v[0];
        else case (g)
            3'd0:    b = a;
            3'd1:    b = o;
            3'd2:    b = ~a;
            3'd3:    b = ~o;
            default: b = x;
        endcase
        for (int i = 0; i < 6; i++) begin
            if (i >= ng)     r[i] = ~b;
            else if (orv[i]) r[i] = o;
            else if (st0[i]) r[i] = 1'b0;
            else             r[i] = b;
        end
        return r;
    endfunction

    always_comb dut_out = model_out(dut_in, m_gate, m_tester, m_stuck0, m_orout);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int lat, input logic p, input logic [5:0] gf,
                                input logic inv, input int nvec);
        exp_t e;
        e.lat = lat; e.pass_e = p; e.gf = gf; e.inv = inv; e.nvec = nvec;
        return e;
    endfunction

    // One test: pulse start, scramble the codes, watch the socket until done (or reset at rst_k).
    task automatic run(input string name, input logic [2:0] g, input logic [2:0] t,
                       input logic un, input logic [5:0] st0, input logic [5:0] orv,
                       input exp_t e, input int mid_k, input int rst_k);
        exp_t       got;
        bit [255:0] seen;
        int         k, nseen, oe_cnt, first_in, last_in;
        bit         fin;
        m_gate = g; m_tester = t; m_stuck0 = st0; m_orout = orv;
        sb.push_back(e);
        @(negedge clk);
        gate = g; tester = t; unsupported = un; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; gate = 3'b111; tester = 3'b111; unsupported = ~un;
        seen = '0; nseen = 0; oe_cnt = 0; first_in = -1; last_in = -1; fin = 1'b0;
        k = 0;
        while (!fin && k < LIMIT) begin
            k++;
            @(negedge clk);
            if (k == 1) check({name, " done cleared after start"}, done, 1'b0);
            if (dut_oe) begin
                oe_cnt++;
                if (!seen[dut_in]) begin seen[dut_in] = 1'b1; nseen++; end
                if (first_in < 0) first_in = int'(dut_in);
                last_in = int'(dut_in);
            end
            if (mid_k > 0 && k == mid_k) start = 1'b1;
            if (mid_k > 0 && k == mid_k + 1) begin
                start = 1'b0;
                check({name, " busy after ignored start"}, busy, 1'b1);
            end
            if (rst_k > 0 && k == rst_k) begin
                check({name, " vector before reset"}, dut_in, 8'd2);
                reset = 1'b1;
                #1;
                check({name, " oe async reset"}, dut_oe, 1'b0);
                check({name, " busy async reset"}, busy, 1'b0);
                check({name, " dut_in async reset"}, dut_in, 8'd0);
                check({name, " gate_fail async reset"}, gate_fail, 6'd0);
                got = sb.pop_front();
                @(negedge clk);
                reset = 1'b0;
                fin = 1'b1;
            end else if (done) begin
                fin = 1'b1;
                got = sb.pop_front();
                check({name, " done latency"}, k, got.lat);
                check({name, " pass"}, pass, got.pass_e);
                check({name, " gate_fail"}, gate_fail, got.gf);
                check({name, " invalid"}, invalid, got.inv);
                check({name, " distinct vectors"}, nseen, got.nvec);
                check({name, " oe cycles"}, oe_cnt, got.nvec * VC);
                check({name, " oe in done"}, dut_oe, 1'b0);
                check({name, " dut_in in done"}, dut_in, 8'd0);
                if (got.nvec > 0) begin
                    check({name, " first vector"}, first_in, 0);
                    check({name, " last vector"}, last_in, got.nvec - 1);
                end
            end
        end
        if (!fin) begin
            check({name, " timeout waiting for done"}, k, e.lat);
            got = sb.pop_front();
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; gate = 3'd0; tester = 3'd0; unsupported = 1'b0;
        m_gate = 3'd0; m_tester = 3'd0; m_stuck0 = 6'd0; m_orout = 6'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset dut_in", dut_in, 8'd0);
        check("reset dut_oe", dut_oe, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset pass", pass, 1'b0);
        check("reset gate_fail", gate_fail, 6'd0);
        check("reset invalid", invalid, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("idle busy", busy, 1'b0);

        run("quad nand", 3'b010, 3'b001, 1'b0, 6'd0, 6'd0, mk(26, 1'b1, 6'd0, 1'b0, 4), 0, 0);
`ifdef IC_SEQ_EARLY_ABORT_EN
        run("hex not stuck", 3'b000, 3'b000, 1'b0, 6'b001000, 6'd0,
            mk(8, 1'b0, 6'b001000, 1'b0, 1), 0, 0);
`else
        run("hex not stuck", 3'b000, 3'b000, 1'b0, 6'b001000, 6'd0,
            mk(14, 1'b0, 6'b001000, 1'b0, 2), 0, 0);
`endif
        run("hex not gate7", 3'b111, 3'b000, 1'b0, 6'd0, 6'd0, mk(14, 1'b1, 6'd0, 1'b0, 2), 0, 0);
        run("triple nor", 3'b011, 3'b010, 1'b0, 6'd0, 6'd0, mk(50, 1'b1, 6'd0, 1'b0, 8), 0, 0);
        run("quad xor", 3'b100, 3'b001, 1'b0, 6'd0, 6'd0, mk(26, 1'b1, 6'd0, 1'b0, 4), 0, 0);
        run("dual or", 3'b001, 3'b011, 1'b0, 6'd0, 6'd0, mk(98, 1'b1, 6'd0, 1'b0, 16), 0, 0);
        run("octal nand", 3'b010, 3'b100, 1'b0, 6'd0, 6'd0,
            mk(1538, 1'b1, 6'd0, 1'b0, 256), 0, 0);
        run("unsupported", 3'b010, 3'b001, 1'b1, 6'd0, 6'd0, mk(2, 1'b0, 6'd0, 1'b1, 0), 0, 0);
        run("tester 110", 3'b010, 3'b110, 1'b0, 6'd0, 6'd0, mk(2, 1'b0, 6'd0, 1'b1, 0), 0, 0);
        run("gate 101", 3'b101, 3'b001, 1'b0, 6'd0, 6'd0, mk(2, 1'b0, 6'd0, 1'b1, 0), 0, 0);
`ifdef IC_SEQ_EARLY_ABORT_EN
        run("dual and bad", 3'b000, 3'b011, 1'b0, 6'd0, 6'b000010,
            mk(14, 1'b0, 6'b000010, 1'b0, 2), 5, 0);
`else
        run("dual and bad", 3'b000, 3'b011, 1'b0, 6'd0, 6'b000010,
            mk(98, 1'b0, 6'b000010, 1'b0, 16), 5, 0);
`endif
        run("quad nand reset", 3'b010, 3'b001, 1'b0, 6'd0, 6'd0,
            mk(26, 1'b1, 6'd0, 1'b0, 4), 0, 16);
        check("idle after reset done", done, 1'b0);
        run("quad nand rerun", 3'b010, 3'b001, 1'b0, 6'd0, 6'd0,
            mk(26, 1'b1, 6'd0, 1'b0, 4), 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ic_test_sequencer.md
# ic_test_sequencer

Sequences one functional test of a logic-gate IC on the tester socket. On `start`, it latches the `gate`/`tester` codes produced by the IC-number decoder and steps an exhaustive input-vector counter. For each vector it drives the DUT inputs, waits a settle interval, samples every gate output and compares it to the expected value. It reports pass/fail overall and per gate to the result/LCD logic.

## Interface
- `SETTLE_CYCLES`, default 50: wait cycles between driving a vector and sampling; legal range 1–1023.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request; honoured only in IDLE or DONE.
- `gate` in 3: gate-function code.
  - 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR.
  - Ignored when `tester`=000, where the function is NOT.
- `tester` in 3: topology code.
  - 000 hex 1-input, 001 quad 2-input, 010 triple 3-input, 011 dual 4-input, 100 single 8-input.
- `unsupported` in 1: decoder's unknown-IC flag (`to_LCD`).
- `dut_out` in 6: sampled gate outputs; bit g = gate g. Unused bits are ignored.
- `dut_in` out 8: input vector, broadcast to all gates; bit k = input k.
- `dut_oe` out 1: socket drive enable.
- `busy` out 1: test in progress.
- `done` out 1: result valid; held until the next accepted `start`.
- `pass` out 1: all active gates matched on all vectors.
- `gate_fail` out 6: sticky per-gate mismatch flags.
- `invalid` out 1: test refused because the IC is unknown or the code is illegal.

## Operation
- States: IDLE, CHECK, APPLY, SETTLE, SAMPLE, DONE.
- IDLE/DONE + `start`:
  - Latch `gate`, `tester`, `unsupported`.
  - Clear `gate_fail`, `pass`, `invalid`, `done` and the vector counter.
  - Go to CHECK.
- CHECK:
  - If `unsupported`=1, `tester`>100, or `gate`>100 with `tester`≠000: set `invalid`=1 and go to DONE.
  - Otherwise go to APPLY.
- Inputs per gate n, active gate count G, vector count V = 2^n:
  - 000: n=1, G=6, V=2
  - 001: n=2, G=4, V=4
  - 010: n=3, G=3, V=8
  - 011: n=4, G=2, V=16
  - 100: n=8, G=1, V=256
- APPLY:
  - `dut_in[n-1:0]` = vector counter; upper bits = 0.
  - Load the settle counter and go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE:
  - Expected value e = f(`dut_in[n-1:0]`): AND-reduce, OR-reduce, their inversions, XOR-reduce (parity), or ~bit0 for NOT.
  - For each g<G: set `gate_fail[g]` if `dut_out[g]`≠e.
  - If the counter = V-1, go to DONE. Otherwise increment the counter and go to APPLY.
  - The counter is 9 bits, so 256 vectors cannot wrap.
- DONE:
  - `done`=1 and `pass` = ~`invalid` & ~|`gate_fail`.
  - `dut_oe`=0 and `dut_in`=0.
- `busy`=1 in CHECK, APPLY, SETTLE, SAMPLE.
- `dut_oe`=1 in APPLY, SETTLE, SAMPLE.
- `start` while busy is ignored.
- Input codes changing mid-test have no effect because they were latched.

## Timing
- Reset values:
  - State = IDLE.
  - `dut_in`=0, `dut_oe`=0, `busy`=0, `done`=0, `pass`=0, `gate_fail`=0, `invalid`=0.
- Reset mid-test returns to IDLE immediately (asynchronous) and all outputs take their reset values.
- `start` sampled at edge T: CHECK at T+1, first APPLY at T+2.
- Each vector takes SETTLE_CYCLES+2 cycles (APPLY 1, SETTLE N, SAMPLE 1).
  - `dut_in` is stable from the APPLY edge through SAMPLE.
  - `dut_out` is sampled on the SAMPLE cycle edge.
- `done` rises at T+2+V·(SETTLE_CYCLES+2).
- Invalid path: `done`=`invalid`=1 at T+2, with `dut_oe` never asserted.
- `start` in DONE clears `done` on the next edge; a new test then begins.

## Configuration
- `IC_SEQ_EARLY_ABORT_EN` defined:
  - The first SAMPLE that sets any `gate_fail` bit goes straight to DONE.
  - `pass`=0; `gate_fail` holds only the gates failed so far.
- Undefined: all V vectors always run, so `gate_fail` is complete.

## Test plan
Bench uses SETTLE_CYCLES=4.
- Good quad NAND: `tester`=001, `gate`=010, DUT model correct → `done` at T+26, `pass`=1, `gate_fail`=000000, 4 distinct `dut_in` values 0–3.
- Hex NOT with gate 3 stuck at 0: `tester`=000 → `pass`=0, `gate_fail`=001000, `done` at T+14. With `IC_SEQ_EARLY_ABORT_EN`, `done` at T+8.
- 8-input NAND, correct → 256 vectors, `done` at T+1538, `pass`=1. `dut_in` last value 0xFF is seen during SAMPLE.
- `unsupported`=1 → `done`=`invalid`=1 at T+2, `pass`=0, `dut_oe` never high. Also `tester`=110 with `unsupported`=0 → same response.
- Dual 4-input AND, gate 1 outputs OR → `gate_fail`=000010. A second `start` issued mid-test is ignored (`busy` stays 1 and the vector sequence is uninterrupted).
- Assert `reset` during SETTLE of vector 2 → `dut_oe`, `busy`, `dut_in` = 0 asynchronously. A later `start` runs a full test from vector 0.
